// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with write-to-read bypass, optional zero register and pending-write scoreboard.
// Reads return one cycle after the request; every port accepts a request every cycle and there is no back-pressure.
module regfile_multiport #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int NUM_RD    = 2,
  parameter bit REG0_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD*ADDR_BITS-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]             rd_enable,
  output logic [NUM_RD*DATA_BITS-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic                          wr_enable,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic [ADDR_BITS-1:0]          rsv_addr,
  input  logic                          rsv_enable,
  output logic [(2**ADDR_BITS)-1:0]     busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0]         regs_q [DEPTH];
  logic [DATA_BITS-1:0]         regs_d [DEPTH];
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_d;
  logic [NUM_RD*DATA_BITS-1:0]  rd_data_q;
  logic [NUM_RD*DATA_BITS-1:0]  rd_data_d;
  logic [NUM_RD-1:0]            rd_busy_q;
  logic [NUM_RD-1:0]            rd_busy_d;

  logic                         wr_ok;
  logic                         rsv_ok;
  logic [ADDR_BITS-1:0]         ra;
  logic                         ra_zero;

  // Register 0 silently ignores writes and reserves when hard-wired to zero.
  always_comb begin
    wr_ok  = wr_enable  && !(REG0_ZERO && (wr_addr  == '0));
    rsv_ok = rsv_enable && !(REG0_ZERO && (rsv_addr == '0));
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Reserve is applied after the write clear so a same-edge reserve wins: the newer writer is pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (REG0_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  // Reads look at the post-update array and scoreboard, which gives the bypass for free.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    ra_zero   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra      = rd_addr[i*ADDR_BITS +: ADDR_BITS];
      ra_zero = REG0_ZERO && (ra == '0);
      if (rd_enable[i]) begin
        rd_data_d[i*DATA_BITS +: DATA_BITS] = ra_zero ? '0 : regs_d[ra];
        rd_busy_d[i]                        = ra_zero ? 1'b0 : busy_d[ra];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport at NUM_RD=4, DATA_BITS=16: directed scenarios, then randomized traffic against a reference model.
module tb_regfile_multiport;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_enable;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [AW-1:0]     wr_addr;
  logic              wr_enable;
  logic [DW-1:0]     wr_data;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_enable;
  logic [DEPTH-1:0]  busy;

  regfile_multiport #(
    .DATA_BITS(DW), .ADDR_BITS(AW), .NUM_RD(NR), .REG0_ZERO(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
    .rsv_addr(rsv_addr), .rsv_enable(rsv_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model: plain arrays updated from the rules in order write, reserve, then reads.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] m_rd_data [NR];
  bit            m_rd_busy [NR];

  task automatic model_step();
    int a;
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
      for (int p = 0; p < NR; p++) begin m_rd_data[p] = '0; m_rd_busy[p] = 0; end
    end else begin
      if (wr_enable && int'(wr_addr) != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (rsv_enable && int'(rsv_addr) != 0) m_busy[rsv_addr] = 1;
      for (int p = 0; p < NR; p++) begin
        if (rd_enable[p]) begin
          a = int'(rd_addr[p*AW +: AW]);
          m_rd_data[p] = (a == 0) ? '0 : m_regs[a];
          m_rd_busy[p] = (a == 0) ? 0 : m_busy[a];
        end
      end
    end
  endtask

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s got %h expected %h", phase, tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [DEPTH-1:0] mb;
    for (int r = 0; r < DEPTH; r++) mb[r] = m_busy[r];
    expect_eq("busy", 64'(busy), 64'(mb));
    for (int p = 0; p < NR; p++) begin
      expect_eq($sformatf("rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(m_rd_data[p]));
      expect_eq($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(m_rd_busy[p]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 1'b0; rd_enable = '0; wr_enable = 1'b0; rsv_enable = 1'b0;
  endtask

  task automatic read_all(input logic [AW-1:0] a, input logic [NR-1:0] en);
    for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = a;
    rd_enable = en;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_enable = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_rsv(input logic [AW-1:0] a);
    rsv_enable = 1'b1; rsv_addr = a;
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    for (int r = 0; r < DEPTH; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    for (int p = 0; p < NR; p++) begin m_rd_data[p] = '0; m_rd_busy[p] = 0; end

    phase = "reset";
    reset = 1'b1; step(); step();
    expect_eq("busy_zero", 64'(busy), 64'd0);
    idle();
    do_write(4'd3, 16'h005A); step();
    idle(); do_rsv(4'd3); read_all(4'd3, 4'b0001); step();
    expect_eq("pre_rd3", 64'(rd_data[0 +: DW]), 64'h5A);
    idle(); reset = 1'b1; do_write(4'd3, 16'h00EE); step();
    expect_eq("busy_cleared", 64'(busy), 64'd0);
    expect_eq("rd_data_cleared", 64'(rd_data), 64'd0);
    expect_eq("rd_busy_cleared", 64'(rd_busy), 64'd0);
    idle(); read_all(4'd3, 4'b0001); step();
    expect_eq("r3_after_reset", 64'(rd_data[0 +: DW]), 64'h0);

    phase = "basic";
    idle(); do_write(4'd5, 16'h00A7); step();
    idle(); read_all(4'd5, 4'b0011); step();
    expect_eq("p0", 64'(rd_data[0 +: DW]), 64'hA7);
    expect_eq("p1", 64'(rd_data[DW +: DW]), 64'hA7);

    phase = "bypass";
    idle(); do_write(4'd7, 16'h0011); step();
    idle(); do_write(4'd7, 16'h0022); read_all(4'd7, 4'b1111); step();
    for (int p = 0; p < NR; p++) expect_eq($sformatf("p%0d", p), 64'(rd_data[p*DW +: DW]), 64'h22);

    phase = "scoreboard";
    idle(); do_rsv(4'd4); step();
    expect_eq("busy4_set", 64'(busy[4]), 64'd1);
    idle(); read_all(4'd4, 4'b0001); step();
    expect_eq("rd_busy_r4", 64'(rd_busy[0]), 64'd1);
    idle(); do_write(4'd4, 16'h0033); step();
    expect_eq("busy4_clr", 64'(busy[4]), 64'd0);
    idle(); do_write(4'd4, 16'h0033); do_rsv(4'd4); read_all(4'd4, 4'b0010); step();
    expect_eq("busy4_both", 64'(busy[4]), 64'd1);
    expect_eq("data4_both", 64'(rd_data[DW +: DW]), 64'h33);
    expect_eq("rd_busy4_both", 64'(rd_busy[1]), 64'd1);
    idle(); do_rsv(4'd4); step();
    expect_eq("busy4_rersv", 64'(busy[4]), 64'd1);

    phase = "zero";
    idle(); do_write(4'd0, 16'h00FF); do_rsv(4'd0); read_all(4'd0, 4'b1111); step();
    expect_eq("busy0", 64'(busy[0]), 64'd0);
    expect_eq("rd0", 64'(rd_data[0 +: DW]), 64'h0);
    expect_eq("rd_busy0", 64'(rd_busy[0]), 64'd0);
    idle(); read_all(4'd0, 4'b0001); step();
    expect_eq("rd0_later", 64'(rd_data[0 +: DW]), 64'h0);

    phase = "hold";
    idle(); do_write(4'd2, 16'hBEEF); step();
    idle(); read_all(4'd2, 4'b1000); step();
    expect_eq("p3_first", 64'(rd_data[3*DW +: DW]), 64'hBEEF);
    idle(); read_all(4'd2, 4'b0000); do_write(4'd2, 16'h1234); step();
    expect_eq("p3_held", 64'(rd_data[3*DW +: DW]), 64'hBEEF);
    idle(); step();
    expect_eq("p3_still", 64'(rd_data[3*DW +: DW]), 64'hBEEF);
    idle(); read_all(4'd2, 4'b1000); step();
    expect_eq("p3_new", 64'(rd_data[3*DW +: DW]), 64'h1234);

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 59) == 0);
      wr_enable  = $urandom_range(0, 1);
      wr_addr    = AW'($urandom_range(0, (c < 300) ? 3 : 15));
      wr_data    = DW'($urandom);
      rsv_enable = $urandom_range(0, 2) == 0;
      rsv_addr   = AW'($urandom_range(0, (c < 300) ? 3 : 15));
      rd_enable  = NR'($urandom);
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, (c < 300) ? 3 : 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
